ex_mem_stage_buf: RTL

- Parametrised EX->MEM pipeline boundary for the 5-stage core, replacing the free-running EX/MEM register.
- Adds valid/ready flow control, flush (bubble insertion) and an optional 2-entry skid buffer, so ex_ready is registered and full throughput is kept under MEM back-pressure.
- Keeps a saturating count of instructions delivered to MEM.
- Sits between the EX stage (ALU, write-data mux) and the MEM stage (data memory, writeback select).

---
 rtl/core_pkg.sv | 27 ++
 rtl/ex_mem_stage_buf_if.sv | 27 ++
 rtl/pipe_skid_slot.sv | 25 ++
 rtl/ex_mem_stage_buf.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared EX->MEM pipeline types: control bits, payload layout and boundary-buffer states.
// Width constants set the default core geometry used by the boundary buffer and its link interface.
package core_pkg;
    localparam int CORE_DATA_W     = 32;
    localparam int CORE_REG_ADDR_W = 5;
    localparam int CORE_INSTR_W    = 32;

    typedef struct packed {
        logic regwrite;
        logic memtoreg;
        logic memwrite;
    } ex_mem_ctrl_t;

    typedef struct packed {
        ex_mem_ctrl_t                 ctrl;
        logic [CORE_DATA_W-1:0]       aluout;
        logic [CORE_DATA_W-1:0]       writedata;
        logic [CORE_REG_ADDR_W-1:0]   writereg;
        logic [CORE_INSTR_W-1:0]      instr;
    } ex_mem_payload_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;
endpackage

// File: rtl/ex_mem_stage_buf_if.sv
// One valid/ready pipeline link carrying EX->MEM control bits, data and the traced instruction.
// The master drives valid and payload; the slave answers with ready.
interface ex_mem_stage_buf_if import core_pkg::*; #(
    parameter int DATA_W     = CORE_DATA_W,
    parameter int REG_ADDR_W = CORE_REG_ADDR_W,
    parameter int INSTR_W    = CORE_INSTR_W
) ();
    logic                  valid;
    logic                  ready;
    logic                  regwrite;
    logic                  memtoreg;
    logic                  memwrite;
    logic [DATA_W-1:0]     aluout;
    logic [DATA_W-1:0]     writedata;
    logic [REG_ADDR_W-1:0] writereg;
    logic [INSTR_W-1:0]    instr;

    modport master (
        output valid, regwrite, memtoreg, memwrite, aluout, writedata, writereg, instr,
        input  ready
    );

    modport slave (
        input  valid, regwrite, memtoreg, memwrite, aluout, writedata, writereg, instr,
        output ready
    );
endinterface

// File: rtl/pipe_skid_slot.sv
// Single valid+payload holding register; load wins over clear so a slot can drain and refill in one cycle.
// Latency 1 cycle; no flow control of its own, the owner decides when to load or clear.
module pipe_skid_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic         vld,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld <= 1'b0;
            q   <= '0;
        end else if (load) begin
            vld <= 1'b1;
            q   <= d;
        end else if (clear) begin
            vld <= 1'b0;
        end
    end
endmodule

// File: rtl/ex_mem_stage_buf.sv
// EX->MEM boundary: valid/ready register stage with flush and optional 2-entry skid, plus a saturating delivery count.
// Latency 1 cycle when empty; SKID=1 gives a registered ex_ready at full throughput, SKID=0 a combinational one.
module ex_mem_stage_buf import core_pkg::*; #(
    parameter int DATA_W     = CORE_DATA_W,
    parameter int REG_ADDR_W = CORE_REG_ADDR_W,
    parameter int INSTR_W    = CORE_INSTR_W,
    parameter int SKID       = 1,
    parameter int CNT_W      = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    ex_mem_stage_buf_if.slave  ex,
    ex_mem_stage_buf_if.master mem,
    output logic [CNT_W-1:0]   delivered_cnt
);
    typedef struct packed {
        ex_mem_ctrl_t          ctrl;
        logic [DATA_W-1:0]     aluout;
        logic [DATA_W-1:0]     writedata;
        logic [REG_ADDR_W-1:0] writereg;
        logic [INSTR_W-1:0]    instr;
    } payload_t;

    localparam int PW = $bits(payload_t);

    payload_t in_pay;
    payload_t main_q;
    logic     main_vld;
    logic     deliver;

    assign in_pay  = {ex.regwrite, ex.memtoreg, ex.memwrite,
                      ex.aluout, ex.writedata, ex.writereg, ex.instr};
    assign deliver = main_vld && mem.ready;

    if (SKID != 0) begin : g_skid
        buf_state_e state;
        buf_state_e nxt;
        logic       ready_q;
        logic       accept;
        logic       main_load, main_clear, skid_load, skid_clear;
        logic       skid_vld;
        payload_t   skid_q;
        payload_t   main_d;

        assign ex.ready = ready_q;
        assign accept   = ex.valid && ready_q && !flush;

        // Skid is only ever written from ONE, so it always holds the younger entry.
        always_comb begin
            nxt        = state;
            main_load  = 1'b0;
            main_clear = 1'b0;
            skid_load  = 1'b0;
            skid_clear = 1'b0;
            main_d     = in_pay;
            if (flush) begin
                nxt        = EMPTY;
                main_clear = 1'b1;
                skid_clear = 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_load = 1'b1;
                            nxt       = ONE;
                        end
                    end
                    ONE: begin
                        if (accept && deliver) begin
                            main_load = 1'b1;
                        end else if (accept) begin
                            skid_load = 1'b1;
                            nxt       = FULL;
                        end else if (deliver) begin
                            main_clear = 1'b1;
                            nxt        = EMPTY;
                        end
                    end
                    FULL: begin
                        if (deliver) begin
                            main_d     = skid_q;
                            main_load  = skid_vld;
                            main_clear = !skid_vld;
                            skid_clear = 1'b1;
                            nxt        = skid_vld ? ONE : EMPTY;
                        end
                    end
                    default: begin
                        nxt        = EMPTY;
                        main_clear = 1'b1;
                        skid_clear = 1'b1;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                state   <= EMPTY;
                ready_q <= 1'b1;
            end else begin
                state   <= nxt;
                ready_q <= (nxt != FULL);
            end
        end

        pipe_skid_slot #(.W(PW)) u_main (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (main_load),
            .clear (main_clear),
            .d     (main_d),
            .vld   (main_vld),
            .q     (main_q)
        );

        pipe_skid_slot #(.W(PW)) u_skid (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (skid_load),
            .clear (skid_clear),
            .d     (in_pay),
            .vld   (skid_vld),
            .q     (skid_q)
        );
    end else begin : g_single
        logic accept;

        assign ex.ready = !main_vld || mem.ready;
        assign accept   = ex.valid && ex.ready && !flush;

        pipe_skid_slot #(.W(PW)) u_main (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (accept),
            .clear (flush || deliver),
            .d     (in_pay),
            .vld   (main_vld),
            .q     (main_q)
        );
    end

    // Bubbles must never write the register file or memory.
    assign mem.valid     = main_vld;
    assign mem.regwrite  = main_vld && main_q.ctrl.regwrite;
    assign mem.memtoreg  = main_vld && main_q.ctrl.memtoreg;
    assign mem.memwrite  = main_vld && main_q.ctrl.memwrite;
    assign mem.aluout    = main_q.aluout;
    assign mem.writedata = main_q.writedata;
    assign mem.writereg  = main_q.writereg;
    assign mem.instr     = main_q.instr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            delivered_cnt <= '0;
        end else if (deliver && (delivered_cnt != {CNT_W{1'b1}})) begin
            delivered_cnt <= delivered_cnt + CNT_W'(1);
        end
    end
endmodule
